rr_mux4_arbiter: RTL

- Round-robin arbiter that shares one mux4 datapath among four single-bit requesters.
- Registers a one-hot grant and the 2-bit select, and drives an internal mux4 instance so that z carries the owner's data bit.
- Enforces a maximum hold time so that no requester can starve the others.
- Sits between the requesters and any shared single-bit sink.

---
 rtl/rr_mux4_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin owner of a shared mux4: 1-clock req->gnt, direct handoff, MAX_HOLD caps ownership under contention.
// No backpressure on z; define ARB_LOCK_EN to add a lock input that suppresses timeout rotation.
module rr_mux4_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       z
);

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [3:0] owner_oh;
  logic [3:0] others;
  logic [1:0] pick_idx;
  logic       lock_act;
  logic       mux_z;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // First set bit of r scanning start, start+1, ... mod 4; caller guarantees r != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] idx;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    pick_idx = 2'd0;
    owner_oh = 4'b0001 << sel_q;
    others   = req & ~owner_oh;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          pick_idx = rr_pick(req, ptr_q);
          state_d  = S_GRANT;
          gnt_d    = 4'b0001 << pick_idx;
          sel_d    = pick_idx;
          busy_d   = 1'b1;
          hold_d   = '0;
        end
      end

      S_GRANT: begin
        if (!req[sel_q]) begin
          // Release wins over timeout; ptr moves past the departing owner either way.
          ptr_d = sel_q + 2'd1;
          if (|req) begin
            pick_idx = rr_pick(req, sel_q + 2'd1);
            gnt_d    = 4'b0001 << pick_idx;
            sel_d    = pick_idx;
            hold_d   = '0;
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            hold_d  = '0;
          end
        end else if ((hold_q == HOLD_LAST) && (|others) && !lock_act) begin
          ptr_d    = sel_q + 2'd1;
          pick_idx = rr_pick(others, sel_q + 2'd1);
          gnt_d    = 4'b0001 << pick_idx;
          sel_d    = pick_idx;
          hold_d   = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  mux4 u_mux4 (
    .d0  (d[0]),
    .d1  (d[1]),
    .d2  (d[2]),
    .d3  (d[3]),
    .sel (sel_q),
    .z   (mux_z)
  );

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign z    = busy_q & mux_z;

endmodule

// Plain 4:1 single-bit multiplexer.
module mux4 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] sel,
  output logic       z
);

  always_comb begin
    z = d0;
    case (sel)
      2'd0: z = d0;
      2'd1: z = d1;
      2'd2: z = d2;
      2'd3: z = d3;
      default: z = d0;
    endcase
  end

endmodule
